// File: rtl/selector_arb_pkg.sv
// Shared types and the round-robin pick helper for the selector arbiter.
package selector_arb_pkg;

  localparam int unsigned MaxEntries = 32;
  localparam int unsigned MaxIdxW    = $clog2(MaxEntries);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set bit of valid at or after ptr, wrapping at n; returns ptr when none is set.
  function automatic int unsigned rr_pick(input logic [MaxEntries-1:0] valid,
                                          input int unsigned           n,
                                          input int unsigned           ptr);
    int unsigned idx;
    int unsigned off;
    int unsigned pick;
    pick = ptr;
    for (int unsigned i = 0; i < MaxEntries; i++) begin
      off = MaxEntries - 1 - i;
      if (off < n) begin
        idx = ptr + off;
        if (idx >= n) idx = idx - n;
        if (valid[MaxIdxW'(idx)]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/selector_if.sv
// Lane selector: muxes one lane out of N (DEMUX=0) or steers one value onto lane sel, zero elsewhere (DEMUX=1).
interface selector_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 32,
  parameter bit          DEMUX = 1'b0
);
  localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0]  lanes;
  logic [W-1:0]    one;
  logic [SelW-1:0] sel;

  if (DEMUX) begin : g_demux
    always_comb begin
      lanes             = '0;
      lanes[sel*W +: W] = one;
    end
  end else begin : g_mux
    assign one = lanes[sel*W +: W];
  end

endinterface

// File: rtl/selector_tag_fifo.sv
// In-order tag FIFO recording the source index of each accepted request.
module selector_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/selector_rr_arbiter.sv
// Round-robin share of one request/response port among ENTRIES requesters; responses return in order.
// Optional per-requester grant counters are built when SELECTOR_ARB_PERF_EN is defined.
module selector_rr_arbiter
  import selector_arb_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned REQ_W   = 32,
  parameter int unsigned RSP_W   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned SelW   = $clog2(ENTRIES),
  localparam int unsigned OccW   = $clog2(DEPTH) + 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [ENTRIES-1:0]       i_req_valid,
  output logic [ENTRIES-1:0]       o_req_ready,
  input  logic [ENTRIES*REQ_W-1:0] i_req_data,
  output logic                     o_req_valid,
  input  logic                     i_req_ready,
  output logic [REQ_W-1:0]         o_req_data,
  output logic [SelW-1:0]          o_req_src,
  input  logic                     i_rsp_valid,
  output logic                     o_rsp_ready,
  input  logic [RSP_W-1:0]         i_rsp_data,
  output logic [ENTRIES-1:0]       o_rsp_valid,
  input  logic [ENTRIES-1:0]       i_rsp_ready,
  output logic [ENTRIES*RSP_W-1:0] o_rsp_data,
  output logic [OccW-1:0]          o_outstanding,
  output logic                     o_err_unexp,
  output logic [ENTRIES*CNT_W-1:0] o_grant_cnt
);

  arb_state_e          state_q, state_d;
  logic [SelW-1:0]     grant_q, grant_d;
  logic [SelW-1:0]     ptr_q, ptr_d;
  logic                err_q;

  logic                in_grant, req_fire, rsp_pop, full_after;
  logic                fifo_full, fifo_empty;
  logic [SelW-1:0]     head, ptr_nxt, pick_idle, pick_next;
  logic [ENTRIES-1:0]  other_valid;

  selector_if #(.N(ENTRIES), .W(REQ_W), .DEMUX(1'b0)) req_sel ();
  selector_if #(.N(ENTRIES), .W(RSP_W), .DEMUX(1'b1)) rsp_sel ();

  assign in_grant    = (state_q == GRANT);
  assign req_fire    = in_grant & i_req_ready;
  assign ptr_nxt     = (grant_q == SelW'(ENTRIES - 1)) ? '0 : grant_q + 1'b1;
  assign other_valid = i_req_valid & ~(ENTRIES'(1'b1) << grant_q);
  assign pick_idle   = SelW'(rr_pick(MaxEntries'(i_req_valid), ENTRIES, 32'(ptr_q)));
  assign pick_next   = SelW'(rr_pick(MaxEntries'(other_valid), ENTRIES, 32'(ptr_nxt)));
  // Only reachable in GRANT where occupancy never exceeds DEPTH-1.
  assign full_after  = (o_outstanding == OccW'(DEPTH - 1)) && !rsp_pop;

  // Request side
  assign req_sel.lanes = i_req_data;
  assign req_sel.sel   = grant_q;
  assign o_req_valid   = in_grant;
  assign o_req_src     = grant_q;
  assign o_req_data    = in_grant ? req_sel.one : '0;
  assign o_req_ready   = in_grant ? (ENTRIES'(i_req_ready) << grant_q) : '0;

  // Response side, steered by the oldest outstanding tag
  assign rsp_sel.one   = i_rsp_data;
  assign rsp_sel.sel   = head;
  assign o_rsp_data    = fifo_empty ? '0 : rsp_sel.lanes;
  assign o_rsp_valid   = (i_rsp_valid && !fifo_empty) ? (ENTRIES'(1'b1) << head) : '0;
  assign o_rsp_ready   = i_rsp_ready[head] & ~fifo_empty;
  assign rsp_pop       = i_rsp_valid & o_rsp_ready;
  assign o_err_unexp   = err_q;

  selector_tag_fifo #(.DEPTH(DEPTH), .W(SelW)) u_tag_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (req_fire),
    .data_i  (grant_q),
    .pop_i   (rsp_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_outstanding)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|i_req_valid && !fifo_full) begin
          grant_d = pick_idle;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (i_req_ready) begin
          ptr_d = ptr_nxt;
          if (|other_valid && !full_after) grant_d = pick_next;
          else                             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      if (i_rsp_valid && fifo_empty) err_q <= 1'b1;
    end
  end

`ifdef SELECTOR_ARB_PERF_EN
  logic [ENTRIES-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (req_fire && (cnt_q[grant_q] != '1)) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
    end
  end

  assign o_grant_cnt = cnt_q;
`else
  assign o_grant_cnt = '0;
`endif

  // Granted requester must hold its request until accepted.
  a_hold_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                 in_grant |-> i_req_valid[grant_q]);

endmodule

// File: tb/tb_selector_rr_arbiter.sv
// Directed bench for selector_rr_arbiter (ENTRIES=4, DEPTH=4), hand-computed expectations.
module tb_selector_rr_arbiter;

  localparam int unsigned ENTRIES = 4;
  localparam int unsigned REQ_W   = 32;
  localparam int unsigned RSP_W   = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 16;

  logic                     i_clk = 1'b0;
  logic                     i_rst_n;
  logic [ENTRIES-1:0]       i_req_valid;
  logic [ENTRIES-1:0]       o_req_ready;
  logic [ENTRIES*REQ_W-1:0] i_req_data;
  logic                     o_req_valid;
  logic                     i_req_ready;
  logic [REQ_W-1:0]         o_req_data;
  logic [1:0]               o_req_src;
  logic                     i_rsp_valid;
  logic                     o_rsp_ready;
  logic [RSP_W-1:0]         i_rsp_data;
  logic [ENTRIES-1:0]       o_rsp_valid;
  logic [ENTRIES-1:0]       i_rsp_ready;
  logic [ENTRIES*RSP_W-1:0] o_rsp_data;
  logic [2:0]               o_outstanding;
  logic                     o_err_unexp;
  logic [ENTRIES*CNT_W-1:0] o_grant_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  selector_rr_arbiter #(
    .ENTRIES(ENTRIES), .REQ_W(REQ_W), .RSP_W(RSP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_data(i_req_data),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_data(o_req_data),
    .o_req_src(o_req_src),
    .i_rsp_valid(i_rsp_valid), .o_rsp_ready(o_rsp_ready), .i_rsp_data(i_rsp_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_outstanding(o_outstanding), .o_err_unexp(o_err_unexp), .o_grant_cnt(o_grant_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_data  = '0;
    i_rsp_ready = '0;
    tick();
    tick();
    chk("rst_req_valid", 128'(o_req_valid), 128'd0);
    chk("rst_req_ready", 128'(o_req_ready), 128'd0);
    chk("rst_rsp_valid", 128'(o_rsp_valid), 128'd0);
    chk("rst_req_src",   128'(o_req_src),   128'd0);
    i_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_req_valid",   128'(o_req_valid),   128'd0);
      chk("idle_outstanding", 128'(o_outstanding), 128'd0);
      chk("idle_err",         128'(o_err_unexp),   128'd0);
    end

    // Single requester 2, one-cycle arbitration latency, then response back to lane 2
    i_req_data  = {32'hDEAD_0003, 32'h0000_A5A5, 32'hDEAD_0001, 32'hDEAD_0000};
    i_req_valid = 4'b0100;
    #1;
    chk("a_no_bypass", 128'(o_req_valid), 128'd0);
    tick();
    chk("a_valid", 128'(o_req_valid), 128'd1);
    chk("a_src",   128'(o_req_src),   128'd2);
    chk("a_data",  128'(o_req_data),  128'h0000_A5A5);
    i_req_ready = 1'b1;
    #1;
    chk("a_req_ready", 128'(o_req_ready), 128'b0100);
    tick();
    i_req_valid = '0;
    i_req_ready = 1'b0;
    chk("a_idle_after", 128'(o_req_valid),   128'd0);
    chk("a_occ1",       128'(o_outstanding), 128'd1);
    i_rsp_valid = 1'b1;
    i_rsp_data  = 32'h0000_5A5A;
    i_rsp_ready = 4'b1111;
    #1;
    chk("a_rsp_valid", 128'(o_rsp_valid), 128'b0100);
    chk("a_rsp_data",  128'(o_rsp_data),  128'h0000_5A5A << 64);
    chk("a_rsp_ready", 128'(o_rsp_ready), 128'd1);
    tick();
    i_rsp_valid = 1'b0;
    chk("a_occ0", 128'(o_outstanding), 128'd0);
    chk("a_err",  128'(o_err_unexp),   128'd0);

    // Pointer back to 0; reqs 1 and 3 with downstream stalled for 5 cycles
    i_rst_n = 1'b0;
    tick();
    i_rst_n     = 1'b1;
    i_req_valid = 4'b1010;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("b_hold_src",   128'(o_req_src),   128'd1);
      chk("b_hold_ready", 128'(o_req_ready), 128'd0);
      tick();
    end
    i_req_ready = 1'b1;
    #1;
    chk("b_ready_1", 128'(o_req_ready), 128'b0010);
    tick();
    i_req_valid = 4'b1000;
    chk("b_src_3", 128'(o_req_src), 128'd3);
    #1;
    chk("b_ready_3", 128'(o_req_ready), 128'b1000);
    tick();
    i_req_valid = '0;
    i_req_ready = 1'b0;
    chk("b_idle", 128'(o_req_valid),   128'd0);
    chk("b_occ2", 128'(o_outstanding), 128'd2);

    // Reset discards tags; a response with nothing outstanding is flagged
    i_rst_n = 1'b0;
    #1;
    chk("c_rst_occ", 128'(o_outstanding), 128'd0);
    tick();
    i_rst_n     = 1'b1;
    i_rsp_valid = 1'b1;
    i_rsp_data  = 32'h0000_BEEF;
    i_rsp_ready = 4'b1111;
    #1;
    chk("c_rsp_ready", 128'(o_rsp_ready), 128'd0);
    chk("c_rsp_valid", 128'(o_rsp_valid), 128'd0);
    chk("c_rsp_data",  128'(o_rsp_data),  128'd0);
    chk("c_err_pre",   128'(o_err_unexp), 128'd0);
    tick();
    i_rsp_valid = 1'b0;
    chk("c_err_set", 128'(o_err_unexp), 128'd1);
    tick();
    chk("c_err_sticky", 128'(o_err_unexp), 128'd1);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    chk("c_err_clr", 128'(o_err_unexp), 128'd0);

    // All requesters streaming until the tag FIFO fills, then one response frees a slot
    i_req_data  = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    i_req_valid = 4'b1111;
    i_req_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("d_src",   128'(o_req_src),   128'(k));
      chk("d_data",  128'(o_req_data),  128'(32'h100 + k));
      chk("d_ready", 128'(o_req_ready), 128'(4'b0001 << k));
      tick();
    end
    chk("d_full_valid", 128'(o_req_valid),   128'd0);
    chk("d_full_occ",   128'(o_outstanding), 128'd4);
    chk("d_full_ready", 128'(o_req_ready),   128'd0);
    tick();
    chk("d_full_hold", 128'(o_req_valid), 128'd0);
    i_rsp_valid = 1'b1;
    i_rsp_data  = 32'h0000_CAFE;
    #1;
    chk("d_rsp_valid", 128'(o_rsp_valid), 128'b0001);
    chk("d_rsp_data",  128'(o_rsp_data),  128'h0000_CAFE);
    chk("d_rsp_ready", 128'(o_rsp_ready), 128'd1);
    tick();
    i_rsp_valid = 1'b0;
    chk("d_pop_valid", 128'(o_req_valid),   128'd0);
    chk("d_pop_occ",   128'(o_outstanding), 128'd3);
    tick();
    chk("d_resume_valid", 128'(o_req_valid), 128'd1);
    chk("d_resume_src",   128'(o_req_src),   128'd0);
    i_rsp_valid = 1'b1;
    i_rsp_ready = 4'b1101;
    #1;
    chk("d_head1_valid", 128'(o_rsp_valid), 128'b0010);
    chk("d_head1_ready", 128'(o_rsp_ready), 128'd0);
    tick();
    i_rsp_valid = 1'b0;
    i_req_ready = 1'b0;
    chk("d_refull_valid", 128'(o_req_valid),   128'd0);
    chk("d_refull_occ",   128'(o_outstanding), 128'd4);
    chk("d_err",          128'(o_err_unexp),   128'd0);
`ifdef SELECTOR_ARB_PERF_EN
    chk("d_grant_cnt", 128'(o_grant_cnt), 128'h0001_0001_0001_0002);
`else
    chk("d_grant_cnt", 128'(o_grant_cnt), 128'd0);
`endif
    i_req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
